// File: rtl/cache_ctrl_pkg.sv
// Shared types and address geometry for the 2-way cache controller.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned TAG_W          = 5;
    localparam int unsigned IDX_W          = 8;
    localparam int unsigned OFF_W          = 3;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_W         = 2;
    localparam int unsigned TAG_LSB        = IDX_W + OFF_W;
    localparam int unsigned IDX_LSB        = OFF_W;
    localparam int unsigned WORD_LSB       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2,
        RETRY = 2'd3
    } state_t;

    // Byte address of one word in a line; words are 16-bit aligned.
    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [IDX_W-1:0]  idx,
        input logic [WORD_W-1:0] word
    );
        return {tag, idx, word, 1'b0};
    endfunction

endpackage

// File: rtl/mem_rd_tracker.sv
// Delay line matching memory read latency; tags each return with its word offset.
module mem_rd_tracker #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [1:0] push_word,
    output logic       ret_valid,
    output logic [1:0] ret_word
);

    logic [MEM_LAT-1:0]      vld;
    logic [MEM_LAT-1:0][1:0] wrd;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            wrd <= '0;
        end else begin
            vld[0] <= push;
            wrd[0] <= push_word;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                vld[i] <= vld[i-1];
                wrd[i] <= wrd[i-1];
            end
        end
    end

    assign ret_valid = vld[MEM_LAT-1];
    assign ret_word  = wrd[MEM_LAT-1];

endmodule

// File: rtl/cache2way_ctrl.sv
// CPU-side controller for a 2-way set-associative cache over a 4-word-line memory.
// Define CACHE_CTRL_REQ_CHECK_EN to reject Rd&Wr and odd addresses with err/Done.
module cache2way_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic              c_enable,
    output logic              c_comp,
    output logic              c_write,
    output logic              c_valid_in,
    output logic              c_invert_victimway,
    output logic [TAG_W-1:0]  c_tag_in,
    output logic [IDX_W-1:0]  c_index,
    output logic [OFF_W-1:0]  c_offset,
    output logic [DATA_W-1:0] c_data_in,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [DATA_W-1:0] c_data_out,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic              c_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_stall
);

    state_t              state;
    logic [WORD_W-1:0]   wb_cnt;
    logic [2:0]          issue_cnt;
    logic [2:0]          recv_cnt;
    logic [TAG_W-1:0]    tag_l;
    logic [IDX_W-1:0]    idx_l;
    logic [WORD_W-1:0]   word_l;
    logic [DATA_W-1:0]   data_l;
    logic                wr_l;

    logic                req;
    logic                req_bad;
    logic                hit;
    logic                issue;
    logic                ret_valid;
    logic [WORD_W-1:0]   ret_word;
    logic                err_req;

    assign req   = Rd | Wr;
    assign hit   = c_hit & c_valid;
    assign issue = (state == ALLOC) && (issue_cnt < 3'(WORDS_PER_LINE)) && !mem_stall && !rst;

`ifdef CACHE_CTRL_REQ_CHECK_EN
    assign req_bad = req & ((Rd & Wr) | Addr[0]);
`else
    logic unused_addr0;
    assign unused_addr0 = Addr[0];
    assign req_bad      = 1'b0;
`endif

    mem_rd_tracker #(.MEM_LAT(MEM_LAT)) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_word (issue_cnt[WORD_W-1:0]),
        .ret_valid (ret_valid),
        .ret_word  (ret_word)
    );

    // State, counters and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wb_cnt    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            tag_l     <= '0;
            idx_l     <= '0;
            word_l    <= '0;
            data_l    <= '0;
            wr_l      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !req_bad && !hit) begin
                        tag_l     <= Addr[TAG_LSB +: TAG_W];
                        idx_l     <= Addr[IDX_LSB +: IDX_W];
                        word_l    <= Addr[WORD_LSB +: WORD_W];
                        data_l    <= DataIn;
                        wr_l      <= Wr;
                        wb_cnt    <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= (c_valid && c_dirty) ? WB : ALLOC;
                    end
                end
                WB: begin
                    if (!mem_stall) begin
                        wb_cnt <= wb_cnt + 2'd1;
                        if (wb_cnt == 2'(WORDS_PER_LINE - 1)) state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (issue) issue_cnt <= issue_cnt + 3'd1;
                    if (ret_valid) begin
                        recv_cnt <= recv_cnt + 3'd1;
                        if (recv_cnt == 3'(WORDS_PER_LINE - 1)) state <= RETRY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cache / memory / CPU outputs; the IDLE compare is combinational for zero-latency hits.
    always_comb begin
        DataOut            = '0;
        Done               = 1'b0;
        Stall              = 1'b0;
        CacheHit           = 1'b0;
        err_req            = 1'b0;
        c_enable           = 1'b0;
        c_comp             = 1'b0;
        c_write            = 1'b0;
        c_valid_in         = 1'b0;
        c_invert_victimway = 1'b0;
        c_tag_in           = '0;
        c_index            = '0;
        c_offset           = '0;
        c_data_in          = '0;
        mem_addr           = '0;
        mem_data_in        = '0;
        mem_wr             = 1'b0;
        mem_rd             = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_bad) begin
                        Done    = 1'b1;
                        err_req = 1'b1;
                    end else if (req) begin
                        c_enable   = 1'b1;
                        c_comp     = 1'b1;
                        c_write    = Wr;
                        c_valid_in = Wr;
                        c_tag_in   = Addr[TAG_LSB +: TAG_W];
                        c_index    = Addr[IDX_LSB +: IDX_W];
                        c_offset   = {Addr[WORD_LSB +: WORD_W], 1'b0};
                        c_data_in  = DataIn;
                        if (hit) begin
                            Done               = 1'b1;
                            CacheHit           = 1'b1;
                            DataOut            = c_data_out;
                            c_invert_victimway = 1'b1;
                        end else begin
                            Stall = 1'b1;
                        end
                    end
                end
                WB: begin
                    Stall       = 1'b1;
                    c_enable    = 1'b1;
                    c_tag_in    = tag_l;
                    c_index     = idx_l;
                    c_offset    = {wb_cnt, 1'b0};
                    mem_wr      = 1'b1;
                    mem_addr    = line_addr(c_tag_out, idx_l, wb_cnt);
                    mem_data_in = c_data_out;
                end
                ALLOC: begin
                    Stall = 1'b1;
                    if (issue_cnt < 3'(WORDS_PER_LINE)) begin
                        mem_rd   = 1'b1;
                        mem_addr = line_addr(tag_l, idx_l, issue_cnt[WORD_W-1:0]);
                    end
                    if (ret_valid) begin
                        c_enable   = 1'b1;
                        c_write    = 1'b1;
                        c_valid_in = 1'b1;
                        c_tag_in   = tag_l;
                        c_index    = idx_l;
                        c_offset   = {ret_word, 1'b0};
                        c_data_in  = mem_data_out;
                    end
                end
                default: begin
                    Stall              = 1'b1;
                    c_enable           = 1'b1;
                    c_comp             = 1'b1;
                    c_write            = wr_l;
                    c_valid_in         = wr_l;
                    c_tag_in           = tag_l;
                    c_index            = idx_l;
                    c_offset           = {word_l, 1'b0};
                    c_data_in          = data_l;
                    Done               = 1'b1;
                    DataOut            = c_data_out;
                    c_invert_victimway = 1'b1;
                end
            endcase
        end
        err = err_req | (c_enable & c_err);
    end

endmodule
